// File: rtl/wlm_reduce.sv
// Pipelined word-level Montgomery reduction: T = C * 2^(-W*L) mod q, q = qH*2^W + 1.
// Every pipeline boundary is an optionally-registered stage; qH travels with its sample.

module wlm_reduce_reg #(
  parameter int WIDTH = 1,
  parameter int EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (EN != 0) begin : g_ff
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= '0;
      else        q <= d;
    end
  end else begin : g_comb
    logic unused_clk;
    assign q          = d;
    assign unused_clk = clk ^ rst_n;
  end
endmodule

module wlm_reduce #(
  parameter int LOGQ    = 60,
  parameter int LOGQH   = 43,
  parameter int CORRECT = 1,
  parameter int FF_IN   = 1,
  parameter int FF_SUB  = 1,
  parameter int FF_MUL  = 1,
  parameter int FF_SUM  = 1,
  parameter int FF_OUT  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LOGQH-1:0]    qH,
  input  logic [2*LOGQ-1:0]   C,
  output logic [LOGQ-1:0]     T
);
  localparam int W   = LOGQ - LOGQH;
  localparam int L   = (LOGQ + W - 1) / W;
  localparam int XW  = 2*LOGQ + 1;
  localparam int PW  = LOGQH + W;
  localparam int HW  = XW - W;
  localparam int SW  = HW + W + 1 + LOGQH;
  localparam int MW  = HW + PW + 1 + LOGQH;
  localparam int AW  = XW + LOGQH;
  localparam int LAT = FF_IN + L*(FF_SUB + FF_MUL + FF_SUM) + FF_OUT;

  logic [XW-1:0]    x [0:L];
  logic [LOGQH-1:0] h [0:L];
  logic [AW-1:0]    in_q;

  wlm_reduce_reg #(.WIDTH(AW), .EN(FF_IN)) u_in (
    .clk(clk), .rst_n(rst), .d({1'b0, C, qH}), .q(in_q)
  );
  assign x[0] = in_q[AW-1:LOGQH];
  assign h[0] = in_q[LOGQH-1:0];

  for (genvar i = 0; i < L; i++) begin : g_iter
    logic [W-1:0]     xl, n, ns;
    logic             cy, cs, cm;
    logic [HW-1:0]    xs, xm;
    logic [LOGQH-1:0] hs, hm;
    logic [PW-1:0]    p, pm;
    logic [SW-1:0]    sub_q;
    logic [MW-1:0]    mul_q;
    logic [AW-1:0]    sum_q;

    // Only X >> W is carried past the negate stage; the low word is folded into N and cy.
    assign xl = x[i][W-1:0];
    assign n  = '0 - xl;
    assign cy = xl[W-1] | n[W-1];

    wlm_reduce_reg #(.WIDTH(SW), .EN(FF_SUB)) u_sub (
      .clk(clk), .rst_n(rst), .d({x[i][XW-1:W], n, cy, h[i]}), .q(sub_q)
    );
    assign {xs, ns, cs, hs} = sub_q;
    assign p = PW'(hs) * PW'(ns);

    wlm_reduce_reg #(.WIDTH(MW), .EN(FF_MUL)) u_mul (
      .clk(clk), .rst_n(rst), .d({xs, p, cs, hs}), .q(mul_q)
    );
    assign {xm, pm, cm, hm} = mul_q;

    wlm_reduce_reg #(.WIDTH(AW), .EN(FF_SUM)) u_sum (
      .clk(clk), .rst_n(rst), .d({XW'(xm) + XW'(pm) + XW'(cm), hm}), .q(sum_q)
    );
    assign x[i+1] = sum_q[AW-1:LOGQH];
    assign h[i+1] = sum_q[LOGQH-1:0];
  end

  logic [XW-1:0]   q_ext, xc;
  logic [LOGQ-1:0] t_d;
  logic            unused_hi;

  assign q_ext = XW'({h[L], {(W-1){1'b0}}, 1'b1});

  always_comb begin
    xc = x[L];
    if (CORRECT != 0 && x[L] >= q_ext) xc = x[L] - q_ext;
  end

  assign t_d       = xc[LOGQ-1:0];
  assign unused_hi = ^{xc[XW-1:LOGQ], h[L]};

  wlm_reduce_reg #(.WIDTH(LOGQ), .EN(FF_OUT)) u_out (
    .clk(clk), .rst_n(rst), .d(t_d), .q(T)
  );
endmodule

// File: tb/tb_wlm_reduce.sv
// Bench for wlm_reduce: pipelined default instance plus an all-combinational CORRECT=0 instance,
// both checked against a bit-serial halving model of C * 2^-68 mod q.

module tb_wlm_reduce;
  localparam int LAT = 14;

  typedef struct {
    int          due;
    logic [59:0] exp;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [42:0] qh, qh_c;
  logic [119:0] c, c_c;
  logic [59:0] t, t_c;

  exp_t pend[$];
  int   cyc;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wlm_reduce #(
    .LOGQ(60), .LOGQH(43), .CORRECT(1),
    .FF_IN(1), .FF_SUB(1), .FF_MUL(1), .FF_SUM(1), .FF_OUT(1)
  ) dut (
    .clk(clk), .rst(rst), .qH(qh), .C(c), .T(t)
  );

  wlm_reduce #(
    .LOGQ(60), .LOGQH(43), .CORRECT(0),
    .FF_IN(0), .FF_SUB(0), .FF_MUL(0), .FF_SUM(0), .FF_OUT(0)
  ) dut_c (
    .clk(clk), .rst(rst), .qH(qh_c), .C(c_c), .T(t_c)
  );

  function automatic logic [255:0] modq(input logic [42:0] hq);
    return (256'(hq) << 17) + 256'd1;
  endfunction

  // Divide by two modulo odd q, 68 times, starting from C mod q.
  function automatic logic [59:0] ref_t(input logic [42:0] hq, input logic [119:0] cv);
    logic [255:0] q, r;
    q = modq(hq);
    r = 256'(cv) % q;
    for (int i = 0; i < 68; i++) r = r[0] ? (r + q) >> 1 : r >> 1;
    return r[59:0];
  endfunction

  function automatic logic [119:0] rand_c(input logic [42:0] hq);
    logic [255:0] r, q;
    q = modq(hq);
    r = 256'({$urandom, $urandom, $urandom, $urandom});
    return 120'(r % (q * q));
  endfunction

  task automatic check(input string tag, input logic [59:0] obs, input logic [59:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (pend.size() > 0 && pend[0].due <= cyc) begin
      e = pend.pop_front();
      check(e.tag, t, e.exp);
    end
  endtask

  task automatic send(input logic [119:0] cv, input logic [42:0] hq,
                      input logic [59:0] exp, input string tag);
    c  = cv;
    qh = hq;
    pend.push_back('{cyc + LAT, exp, tag});
  endtask

  task automatic prefill_zero();
    for (int k = 1; k < LAT; k++) pend.push_back('{cyc + k, 60'd0, "post_reset_zero"});
  endtask

  task automatic comb(input logic [119:0] cv, input logic [42:0] hq);
    logic [255:0] red;
    c_c  = cv;
    qh_c = hq;
    #1;
    red = 256'(t_c) % modq(hq);
    check("comb", red[59:0], ref_t(hq, cv));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [42:0]  hq;
    logic [119:0] cv;

    rst  = 1'b0;
    c    = 120'd5;
    qh   = 43'd1;
    c_c  = '0;
    qh_c = 43'd1;
    cyc  = 0;

    #3;
    check("reset_async", t, 60'd0);
    repeat (3) begin
      step();
      check("reset_hold", t, 60'd0);
    end

    rst = 1'b1;
    prefill_zero();
    send(120'd5, 43'd1, 60'd5, "reset_c5");
    step(); send(120'd0,      43'd1, 60'd0, "c_zero");
    step(); send(120'd131073, 43'd1, 60'd0, "c_eq_q");
    step(); send(120'd131080, 43'd1, 60'd7, "c_q_plus7");
    cv = 120'd1 << 34;
    step(); send(cv,          43'd1, 60'd1, "c_max");
    step(); send(120'd5,      43'd1, 60'd5, "b2b_5");
    step(); send(120'd7,      43'd1, 60'd7, "b2b_7");

    comb(120'd0, 43'd1);
    comb(120'd131073, 43'd1);
    comb(120'd131080, 43'd1);
    comb(cv, 43'd1);

    for (int i = 0; i < 1000; i++) begin
      step();
      hq = ($urandom_range(0, 1) == 0) ? 43'd1 : {1'b1, 10'($urandom), $urandom};
      cv = rand_c(hq);
      send(cv, hq, ref_t(hq, cv), "stream");
      hq = {1'b0, 10'($urandom), $urandom};
      comb(rand_c(hq), hq);
    end
    repeat (LAT) step();

    for (int k = 0; k < 5; k++) begin
      step();
      hq = {1'b1, 10'($urandom), $urandom};
      cv = rand_c(hq);
      send(cv, hq, ref_t(hq, cv), "inflight");
    end
    #2;
    rst = 1'b0;
    #1;
    check("reset_midstream", t, 60'd0);
    pend.delete();
    repeat (3) begin
      step();
      check("reset_midstream_hold", t, 60'd0);
    end

    rst = 1'b1;
    prefill_zero();
    send(120'd9, 43'd1, 60'd9, "after_reset_c9");
    repeat (LAT + 2) step();

    n_cmp++;
    assert (pend.size() == 0) else begin
      n_err++;
      $error("FAIL drain observed=%0d expected=0", pend.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
